// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state encodings and parity-mode constants
package parity_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/xor_gate.sv
// xor_gate: two-input exclusive-or
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: collects an LSB-first serial frame plus parity bit and reports data and parity result
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic              frame_valid,
  output logic              busy
);
  localparam int   CW   = $clog2(DATA_W) + 1;
  localparam logic MODE = (ODD != 0) ? PAR_ODD : PAR_EVEN;
  state_t            state, state_nxt;
  logic              acc, acc_x;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              last_bit;
  xor_gate u_xor (.a(acc), .b(bit_in), .y(acc_x));
  assign last_bit = cnt == CW'(DATA_W - 1);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE)   ? (start ? DATA : IDLE) :
                (state == DATA)   ? ((bit_valid && last_bit) ? PARITY : DATA) :
                (state == PARITY) ? (bit_valid ? DONE : PARITY) : IDLE;
  end
  // frame_valid and busy are registered from the next state so they track DONE and non-IDLE exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      parity_err  <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= state_nxt == DONE;
      busy        <= state_nxt != IDLE;
      if (state == IDLE && start) begin
        acc   <= 1'b0;
        cnt   <= '0;
        shreg <= '0;
      end
      if (state == DATA && bit_valid) begin
        acc   <= acc_x;
        cnt   <= cnt + CW'(1);
        shreg <= shreg | (DATA_W'(bit_in) << cnt);
      end
      if (state == PARITY && bit_valid) begin
        data_out   <= shreg;
        parity_err <= acc_x != MODE;
      end
    end
  end
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: scoreboard bench driving an even- and an odd-parity checker in parallel
module tb_serial_parity_checker;
  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst, start, bit_in, bit_valid;
  logic [7:0] dout_e, dout_o;
  logic       perr_e, perr_o, fv_e, fv_o, busy_e, busy_o;
  exp_t       q_e[$], q_o[$];
  int         errors = 0, checks = 0, pulses_e = 0, pulses_o = 0, nexp = 0;
  serial_parity_checker #(.DATA_W(8), .ODD(0)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_e), .parity_err(perr_e), .frame_valid(fv_e), .busy(busy_e)
  );
  serial_parity_checker #(.DATA_W(8), .ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .data_out(dout_o), .parity_err(perr_o), .frame_valid(fv_o), .busy(busy_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && fv_e) begin
      exp_t x;
      pulses_e++;
      if (q_e.size() == 0) check("even_unexpected_pulse", 1, 0);
      else begin
        x = q_e.pop_front();
        check("even_data", dout_e, x.d);
        check("even_perr", perr_e, x.e);
      end
    end
    if (!rst && fv_o) begin
      exp_t x;
      pulses_o++;
      if (q_o.size() == 0) check("odd_unexpected_pulse", 1, 0);
      else begin
        x = q_o.pop_front();
        check("odd_data", dout_o, x.d);
        check("odd_perr", perr_o, x.e);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask
  task automatic frame(input logic [7:0] d, input logic p, input logic e_err, input bit gaps,
                       input bit start_mid, input bit start_done, input bit idle_bv);
    start = 1'b1;
    bit_in = 1'b1;
    bit_valid = idle_bv;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    check("busy_after_start", busy_e, 1);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 5)) tick();
      start = start_mid && i == 3;
      send_bit(d[i]);
      start = 1'b0;
    end
    check("busy_in_parity", busy_e, 1);
    q_e.push_back('{d, e_err});
    q_o.push_back('{d, !e_err});
    nexp++;
    send_bit(p);
    check("busy_in_done", busy_e, 1);
    start = start_done;
    tick();
    start = 1'b0;
    check("busy_back_idle", busy_e, 0);
    check("data_hold", dout_e, d);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    tick(); tick();
    check("rst_data", dout_e, 0);
    check("rst_perr", perr_e, 0);
    check("rst_fv", fv_e, 0);
    check("rst_busy", busy_e, 0);
    rst = 1'b0;
    frame(8'hA5, 1'b0, 1'b0, 0, 0, 0, 0);
    frame(8'hA5, 1'b1, 1'b1, 0, 0, 0, 0);
    frame(8'h3C, 1'b0, 1'b0, 1, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy_e, 0);
    check("abort_data", dout_e, 0);
    check("abort_fv", fv_e, 0);
    tick();
    rst = 1'b0;
    frame(8'hFF, 1'b0, 1'b0, 0, 0, 0, 0);
    frame(8'h5A, 1'b1, 1'b1, 0, 1, 1, 0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    check("idle_bv_busy", busy_e, 0);
    check("idle_bv_data", dout_e, 8'h5A);
    frame(8'h80, 1'b1, 1'b0, 0, 0, 0, 1);
    frame(8'h01, 1'b1, 1'b0, 0, 0, 0, 0);
    frame(8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
    tick(); tick();
    check("even_pulse_count", pulses_e, nexp);
    check("odd_pulse_count", pulses_o, nexp);
    check("even_queue_empty", q_e.size(), 0);
    check("odd_queue_empty", q_o.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame (range 1..32).
REQ-002 Parameter: ODD, default 0; 0 = even parity, 1 = odd parity.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  frame-start pulse, sampled only in IDLE.
REQ-006 Port: bit_in  input  1  serial data/parity bit, LSB first.
REQ-007 Port: bit_valid  input  1  bit_in is consumed on this cycle.
REQ-008 Port: data_out  output  DATA_W  last completed frame's data bits.
REQ-009 Port: parity_err  output  1  parity result of last completed frame.
REQ-010 Port: frame_valid  output  1  one-cycle pulse marking a completed frame.
REQ-011 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, DATA, PARITY, DONE.
REQ-013 IDLE -> DATA on start=1; the accumulator, bit counter and shift register are cleared in the same edge.
REQ-014 IDLE: bit_valid is ignored; start and bit_valid together in IDLE means only start is taken and the bit is not consumed.
REQ-015 DATA: on each bit_valid=1, bit i of the frame goes to shift register bit i (LSB first), acc <= acc XOR bit_in, counter increments.
REQ-016 DATA: bit_valid=0 cycles hold all state; gaps of any length are legal.
REQ-017 DATA -> PARITY on the edge that accepts data bit DATA_W-1; counter width is clog2(DATA_W)+1 and it never wraps.
REQ-018 PARITY: on bit_valid=1, the next parity_err is ((acc XOR bit_in) != ODD); data_out is loaded from the shift register; go to DONE.
REQ-019 DONE: frame_valid=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-020 Latency: frame_valid is asserted on the cycle after the parity bit is accepted.
REQ-021 data_out and parity_err change only when entering DONE and hold until the next frame completes.
REQ-022 start outside IDLE is ignored; a frame is never restarted mid-stream.
REQ-023 start in DONE is ignored; the earliest new frame begins with start in the following IDLE cycle.
REQ-024 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-025 rst=1 immediately forces IDLE, data_out=0, parity_err=0, frame_valid=0, busy=0, accumulator=0 and counter=0.
REQ-026 Reset mid-frame discards the partial frame; no frame_valid pulse is produced for it.
REQ-027 After rst deasserts, the first start is accepted on the first rising edge.

Structure
REQ-028 Shared package parity_pkg holds the FSM state encodings (2-bit) and the EVEN/ODD parity constants.
REQ-029 The accumulator feedback XOR is one instance of the team's existing xor_gate (a, b -> y); no other sub-module is used.
REQ-030 Target size is 120-400 lines of RTL in a single file plus the package.

Verification
REQ-031 DATA_W=8, ODD=0: start, then bits of 0xA5 LSB first, then parity 0 -> frame_valid pulse, data_out=0xA5, parity_err=0.
REQ-032 Same frame with parity 1 -> parity_err=1, data_out=0xA5; with ODD=1, parity 1 -> parity_err=0.
REQ-033 Frame 0x3C with random bit_valid gaps of 0-5 cycles -> data_out=0x3C, frame_valid exactly once, busy high from start+1 until the DONE cycle.
REQ-034 rst pulsed after 4 data bits, then a full frame 0xFF with parity 0 -> no pulse for the aborted frame, then data_out=0xFF, parity_err=0.
REQ-035 start asserted in DATA and in DONE, and bit_valid asserted in IDLE -> no effect on the frame; counter and data_out unchanged.
REQ-036 Back-to-back frames 0x01 (parity 1) then 0x00 (parity 0) -> two frame_valid pulses, each with parity_err=0, and data_out updated at each.
